eh2_lsu_ecc_scrub: RTL and testbench
====================================

# eh2_lsu_ecc_scrub

Corrected-data writeback (scrub) sequencer downstream of the LSU ECC decode stage. It captures single-bit ECC error events and the corrected words in DC3, carries them through DC4/DC5 with flush kill, and queues committed events in a small FIFO. Each queued event is drained as one or two DCCM bank writes over a req/gnt handshake with the DCCM write arbiter. An optional saturating counter records committed corrections.

## Interface
- DEPTH, 2: FIFO entries (power of 2, ≥2)
- DCCM_BITS, 16: DCCM byte-address width
- DATA_W, 32: DCCM bank data width
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- single_ecc_error_lo_dc3  in  1  corrected error, lo bank
- single_ecc_error_hi_dc3  in  1  corrected error, hi bank
- lsu_addr_dc3  in  DCCM_BITS  start address (lo bank)
- end_addr_dc3  in  DCCM_BITS  end address (hi bank)
- sec_data_lo_dc3  in  DATA_W  corrected lo word
- sec_data_hi_dc3  in  DATA_W  corrected hi word
- flush_dc4  in  1  kill DC4 event
- flush_dc5  in  1  kill DC5 event
- scrub_wr_req  out  1  DCCM write request
- scrub_wr_gnt  in  1  arbiter grant
- scrub_wr_addr  out  DCCM_BITS  write address
- scrub_wr_data  out  DATA_W  write data (ECC regenerated by the consumer)
- scrub_full  out  1  FIFO full
- scrub_drop  out  1  one-cycle pulse when a committed event is discarded
- scrub_err_cnt  out  16  committed correction count

## Operation
- DC3 capture: event valid = lo | hi. Stage registers hold {mask_lo, mask_hi, lsu_addr, end_addr, data_lo, data_hi}.
- DC4 valid = DC3 valid & ~flush_dc4.
- DC5 valid = DC4 valid & ~flush_dc4 & ~flush_dc5. A DC5-valid event commits in that cycle.
- Data registers load only when the incoming valid is 1.
- Enqueue:
  - Accepted if not full, or if full and a pop occurs in the same cycle.
  - Otherwise the event is discarded and scrub_drop pulses.
  - FIFO pointers are log2(DEPTH)+1 bits. Full = MSBs differ and LSBs are equal; empty = pointers equal.
- Drain FSM, states IDLE, WR_LO, WR_HI:
  - IDLE → WR_LO if not empty and head mask_lo = 1; IDLE → WR_HI if not empty and head mask_lo = 0.
  - WR_LO:
    - Request is {lsu_addr, data_lo}.
    - On gnt: go to WR_HI if mask_hi = 1. Otherwise pop the entry and return to IDLE.
  - WR_HI:
    - Request is {end_addr, data_hi}.
    - On gnt: pop the entry and return to IDLE.
  - scrub_wr_req = (state ≠ IDLE). Address and data are held stable until gnt.
- Counter (if enabled): +1 per committed event, whether accepted or dropped. Increment is +2 when both masks are set. Saturates at 16'hFFFF.

## Timing
- Reset values:
  - scrub_wr_req 0, scrub_wr_addr 0, scrub_wr_data 0.
  - scrub_full 0, scrub_drop 0, scrub_err_cnt 0.
  - Pointers 0, stage valids 0, state IDLE.
- Latency: event present in DC3 at cycle N → DC5 at N+2 → entry visible at N+3 → scrub_wr_req = 1 at N+3 (FSM leaves IDLE at the N+3 edge; req is combinational from state).
  - Correction: the FSM samples non-empty at N+3, so scrub_wr_req first asserts at N+4.
- Handshake:
  - A write completes on the clk edge where req & gnt are both 1.
  - gnt without req is ignored.
  - req never drops without a gnt, except on rst.
- Back-to-back: a new head entry may start in the cycle after a pop (via IDLE, 1 bubble).
- Simultaneous enqueue + pop while full: both happen, and full stays 1.
- Flush of a DC5 event in its commit cycle: no enqueue, no drop, no count.
- Reset mid-write: req drops the next cycle and the queued entries are lost.

## Configuration
- LSU_ECC_SCRUB_CNT_EN defined: scrub_err_cnt is the saturating counter.
- LSU_ECC_SCRUB_CNT_EN undefined: no counter flops; scrub_err_cnt is tied to 16'h0.

## Test plan
- Lo-only error: addr 0x0104, data 0xDEADBEEF, gnt always 1 → single write {0x0104, 0xDEADBEEF} with req first high at N+4, one cycle. Count = 1.
- Dual error: lsu_addr 0x0106, end_addr 0x0109, gnt held 0 for 3 cycles → req stays high with lo addr/data held stable. Then 0x0106 is written, followed by 0x0109. Count +2.
- Flush: flush_dc4 on event A, flush_dc5 on event B, event C clean → only C is written. Count = 1, drop never pulses.
- Overflow: DEPTH=2 with gnt = 0, commit 3 events → scrub_full = 1 after the second. The third produces a scrub_drop pulse and the count = 3. Releasing gnt drains exactly 2 entries.
- Full + pop: full FIFO with a gnt pop in the same cycle as a commit → event accepted, no drop, full stays 1.
- Reset mid-WR_HI and counter saturation: preload the count to 0xFFFE, commit a dual error → count = 0xFFFF. Assert rst during WR_HI → the next cycle shows req = 0, empty, count = 0 (macro defined).

Source files
------------

// File: rtl/eh2_lsu_ecc_scrub_if.sv
// rtl/eh2_lsu_ecc_scrub_if.sv - scrub write bus between the scrub sequencer and the DCCM write arbiter
//
// Signals:
//   scrub_wr_req   sequencer -> arbiter  write request, held until granted
//   scrub_wr_gnt   arbiter -> sequencer  grant, the write completes on req & gnt
//   scrub_wr_addr  sequencer -> arbiter  DCCM byte address
//   scrub_wr_data  sequencer -> arbiter  corrected bank word (ECC regenerated by the consumer)
// Modports: master (sequencer side), slave (arbiter side).
interface eh2_lsu_ecc_scrub_if #(
    parameter int DCCM_BITS = 16,
    parameter int DATA_W    = 32
);
    logic                 scrub_wr_req;
    logic                 scrub_wr_gnt;
    logic [DCCM_BITS-1:0] scrub_wr_addr;
    logic [DATA_W-1:0]    scrub_wr_data;

    modport master (
        output scrub_wr_req,
        output scrub_wr_addr,
        output scrub_wr_data,
        input  scrub_wr_gnt
    );

    modport slave (
        input  scrub_wr_req,
        input  scrub_wr_addr,
        input  scrub_wr_data,
        output scrub_wr_gnt
    );
endinterface

// File: rtl/eh2_lsu_ecc_scrub.sv
// rtl/eh2_lsu_ecc_scrub.sv - corrected-data writeback (scrub) sequencer for LSU single-bit ECC errors
//
// Captures single-bit ECC error events in DC3, carries them through DC4/DC5 with
// flush kill, queues committed events in a DEPTH-entry FIFO and drains each entry
// as one or two DCCM bank writes over the scrub write bus.
//
// Optional feature: define LSU_ECC_SCRUB_CNT_EN to build the saturating
// correction counter; otherwise scrub_err_cnt is tied to zero.
//
// Ports:
//   clk, rst                  core clock, synchronous active-high reset
//   single_ecc_error_lo/hi_dc3  corrected error flags per bank
//   lsu_addr_dc3, end_addr_dc3  lo / hi bank addresses
//   sec_data_lo/hi_dc3        corrected words
//   flush_dc4, flush_dc5      kill the event in DC4 / DC5
//   wr                        scrub write bus (master side)
//   scrub_full                FIFO full
//   scrub_drop                one-cycle pulse per discarded committed event
//   scrub_err_cnt             committed correction count
module eh2_lsu_ecc_scrub #(
    parameter int DEPTH     = 2,
    parameter int DCCM_BITS = 16,
    parameter int DATA_W    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 single_ecc_error_lo_dc3,
    input  logic                 single_ecc_error_hi_dc3,
    input  logic [DCCM_BITS-1:0] lsu_addr_dc3,
    input  logic [DCCM_BITS-1:0] end_addr_dc3,
    input  logic [DATA_W-1:0]    sec_data_lo_dc3,
    input  logic [DATA_W-1:0]    sec_data_hi_dc3,
    input  logic                 flush_dc4,
    input  logic                 flush_dc5,
    eh2_lsu_ecc_scrub_if.master  wr,
    output logic                 scrub_full,
    output logic                 scrub_drop,
    output logic [15:0]          scrub_err_cnt
);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR_LO = 2'd1,
        WR_HI = 2'd2
    } state_t;

    // ---------------- DC3 -> DC4 -> DC5 pipeline ----------------
    logic                 dc3_valid;
    logic                 dc4_valid, dc5_valid;
    logic                 dc4_mask_lo, dc4_mask_hi, dc5_mask_lo, dc5_mask_hi;
    logic [DCCM_BITS-1:0] dc4_lsu_addr, dc4_end_addr, dc5_lsu_addr, dc5_end_addr;
    logic [DATA_W-1:0]    dc4_data_lo, dc4_data_hi, dc5_data_lo, dc5_data_hi;
    logic                 dc4_fwd;
    logic                 commit;

    assign dc3_valid = single_ecc_error_lo_dc3 | single_ecc_error_hi_dc3;
    // flush_dc4 kills the event while it sits in DC4, flush_dc5 in its commit cycle
    assign dc4_fwd   = dc4_valid & ~flush_dc4;
    assign commit    = dc5_valid & ~flush_dc5;

    always_ff @(posedge clk) begin
        if (rst) begin
            dc4_valid <= 1'b0;
            dc5_valid <= 1'b0;
        end else begin
            dc4_valid <= dc3_valid;
            dc5_valid <= dc4_fwd;
        end
    end

    // Payload registers only move with a valid event, saving toggles on idle cycles
    always_ff @(posedge clk) begin
        if (dc3_valid) begin
            dc4_mask_lo  <= single_ecc_error_lo_dc3;
            dc4_mask_hi  <= single_ecc_error_hi_dc3;
            dc4_lsu_addr <= lsu_addr_dc3;
            dc4_end_addr <= end_addr_dc3;
            dc4_data_lo  <= sec_data_lo_dc3;
            dc4_data_hi  <= sec_data_hi_dc3;
        end
        if (dc4_fwd) begin
            dc5_mask_lo  <= dc4_mask_lo;
            dc5_mask_hi  <= dc4_mask_hi;
            dc5_lsu_addr <= dc4_lsu_addr;
            dc5_end_addr <= dc4_end_addr;
            dc5_data_lo  <= dc4_data_lo;
            dc5_data_hi  <= dc4_data_hi;
        end
    end

    // ---------------- event FIFO ----------------
    logic                 fifo_mask_lo  [DEPTH];
    logic                 fifo_mask_hi  [DEPTH];
    logic [DCCM_BITS-1:0] fifo_lsu_addr [DEPTH];
    logic [DCCM_BITS-1:0] fifo_end_addr [DEPTH];
    logic [DATA_W-1:0]    fifo_data_lo  [DEPTH];
    logic [DATA_W-1:0]    fifo_data_hi  [DEPTH];
    logic [PW:0]          wptr, rptr;
    logic [PW-1:0]        widx, ridx;
    logic                 empty, full;
    logic                 push, pop;

    assign widx  = wptr[PW-1:0];
    assign ridx  = rptr[PW-1:0];
    assign empty = (wptr == rptr);
    assign full  = (wptr[PW] != rptr[PW]) && (widx == ridx);
    // When full, a same-cycle pop frees the head slot, which is the slot written
    assign push  = commit & (~full | pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr       <= '0;
            rptr       <= '0;
            scrub_drop <= 1'b0;
        end else begin
            if (push) wptr <= wptr + (PW+1)'(1);
            if (pop)  rptr <= rptr + (PW+1)'(1);
            scrub_drop <= commit & ~push;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mask_lo[widx]  <= dc5_mask_lo;
            fifo_mask_hi[widx]  <= dc5_mask_hi;
            fifo_lsu_addr[widx] <= dc5_lsu_addr;
            fifo_end_addr[widx] <= dc5_end_addr;
            fifo_data_lo[widx]  <= dc5_data_lo;
            fifo_data_hi[widx]  <= dc5_data_hi;
        end
    end

    assign scrub_full = full;

    // ---------------- drain FSM ----------------
    state_t               state, state_nxt;
    logic                 req;
    logic [DCCM_BITS-1:0] addr;
    logic [DATA_W-1:0]    data;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Address/data come straight from the head entry, which cannot change
    // until the pop at the final grant, so they stay stable while waiting.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        req       = 1'b0;
        addr      = '0;
        data      = '0;
        case (state)
            IDLE: begin
                if (!empty) state_nxt = fifo_mask_lo[ridx] ? WR_LO : WR_HI;
            end
            WR_LO: begin
                req  = 1'b1;
                addr = fifo_lsu_addr[ridx];
                data = fifo_data_lo[ridx];
                if (wr.scrub_wr_gnt) begin
                    if (fifo_mask_hi[ridx]) begin
                        state_nxt = WR_HI;
                    end else begin
                        pop       = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            WR_HI: begin
                req  = 1'b1;
                addr = fifo_end_addr[ridx];
                data = fifo_data_hi[ridx];
                if (wr.scrub_wr_gnt) begin
                    pop       = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign wr.scrub_wr_req  = req;
    assign wr.scrub_wr_addr = addr;
    assign wr.scrub_wr_data = data;

    // ---------------- correction counter ----------------
`ifdef LSU_ECC_SCRUB_CNT_EN
    logic [15:0] err_cnt;
    logic [16:0] cnt_sum;

    // Counts every committed event, accepted or dropped; a dual-bank event counts twice
    assign cnt_sum = {1'b0, err_cnt} + ((dc5_mask_lo & dc5_mask_hi) ? 17'd2 : 17'd1);

    always_ff @(posedge clk) begin
        if (rst)         err_cnt <= 16'h0;
        else if (commit) err_cnt <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    end

    assign scrub_err_cnt = err_cnt;
`else
    assign scrub_err_cnt = 16'h0;
`endif
endmodule

// File: tb/tb_eh2_lsu_ecc_scrub.sv
// tb/tb_eh2_lsu_ecc_scrub.sv - scoreboard testbench for eh2_lsu_ecc_scrub
module tb_eh2_lsu_ecc_scrub;
    localparam int DEPTH     = 2;
    localparam int DCCM_BITS = 16;
    localparam int DATA_W    = 32;
`ifdef LSU_ECC_SCRUB_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 err_lo, err_hi;
    logic [DCCM_BITS-1:0] lsu_addr, end_addr;
    logic [DATA_W-1:0]    data_lo, data_hi;
    logic                 flush_dc4, flush_dc5;
    logic                 scrub_full, scrub_drop;
    logic [15:0]          scrub_err_cnt;

    eh2_lsu_ecc_scrub_if #(.DCCM_BITS(DCCM_BITS), .DATA_W(DATA_W)) wr_if ();

    eh2_lsu_ecc_scrub #(.DEPTH(DEPTH), .DCCM_BITS(DCCM_BITS), .DATA_W(DATA_W)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .single_ecc_error_lo_dc3 (err_lo),
        .single_ecc_error_hi_dc3 (err_hi),
        .lsu_addr_dc3            (lsu_addr),
        .end_addr_dc3            (end_addr),
        .sec_data_lo_dc3         (data_lo),
        .sec_data_hi_dc3         (data_hi),
        .flush_dc4               (flush_dc4),
        .flush_dc5               (flush_dc5),
        .wr                      (wr_if.master),
        .scrub_full              (scrub_full),
        .scrub_drop              (scrub_drop),
        .scrub_err_cnt           (scrub_err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t      exp_q[$];
    int       total = 0;
    int       bad   = 0;
    int       drop_seen = 0;
    int       drop_base;
    int       exp_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int sat_add(input int c, input int inc);
        return (c + inc > 65535) ? 65535 : c + inc;
    endfunction

    // Write monitor: every completed handshake is checked against the scoreboard
    always @(negedge clk) begin
        if (!rst && wr_if.scrub_wr_req && wr_if.scrub_wr_gnt) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got addr %h data %h expected no write",
                         wr_if.scrub_wr_addr, wr_if.scrub_wr_data);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", 32'(wr_if.scrub_wr_addr), 32'(e.addr));
                chk("wr_data", wr_if.scrub_wr_data, e.data);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && scrub_drop) drop_seen++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ev(input logic lo, input logic hi, input logic [15:0] a, input logic [15:0] ea,
                          input logic [31:0] dl, input logic [31:0] dh);
        err_lo   = lo;
        err_hi   = hi;
        lsu_addr = a;
        end_addr = ea;
        data_lo  = dl;
        data_hi  = dh;
    endtask

    // Drive one event for one cycle; returns one cycle after it was in DC3
    task automatic send(input logic lo, input logic hi, input logic [15:0] a, input logic [15:0] ea,
                        input logic [31:0] dl, input logic [31:0] dh);
        set_ev(lo, hi, a, ea, dl, dh);
        step();
        set_ev(1'b0, 1'b0, 16'h0, 16'h0, 32'h0, 32'h0);
    endtask

    function automatic logic [31:0] exp_count();
        return CNT_EN ? 32'(exp_cnt) : 32'h0;
    endfunction

    initial begin
        rst = 1'b1;
        wr_if.scrub_wr_gnt = 1'b0;
        flush_dc4 = 1'b0;
        flush_dc5 = 1'b0;
        set_ev(1'b0, 1'b0, 16'h0, 16'h0, 32'h0, 32'h0);

        // reset state
        repeat (3) step();
        @(negedge clk);
        chk("rst_req",  32'(wr_if.scrub_wr_req), 32'h0);
        chk("rst_addr", 32'(wr_if.scrub_wr_addr), 32'h0);
        chk("rst_data", wr_if.scrub_wr_data, 32'h0);
        chk("rst_full", 32'(scrub_full), 32'h0);
        chk("rst_drop", 32'(scrub_drop), 32'h0);
        chk("rst_cnt",  32'(scrub_err_cnt), 32'h0);
        step();
        rst = 1'b0;
        step();
        drop_base = drop_seen;

        // lo-only error, gnt always 1: req first high at N+4 for one cycle
        wr_if.scrub_wr_gnt = 1'b1;
        exp_q.push_back({16'h0104, 32'hDEADBEEF});
        exp_cnt = sat_add(exp_cnt, 1);
        send(1'b1, 1'b0, 16'h0104, 16'h0000, 32'hDEADBEEF, 32'h0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("t1_req_n3", 32'(wr_if.scrub_wr_req), 32'h0);
        @(negedge clk);
        chk("t1_req_n4", 32'(wr_if.scrub_wr_req), 32'h1);
        @(negedge clk);
        chk("t1_req_n5", 32'(wr_if.scrub_wr_req), 32'h0);
        chk("t1_cnt", 32'(scrub_err_cnt), exp_count());
        step();

        // dual error with gnt held low for 3 cycles
        wr_if.scrub_wr_gnt = 1'b0;
        exp_q.push_back({16'h0106, 32'h11112222});
        exp_q.push_back({16'h0109, 32'h33334444});
        exp_cnt = sat_add(exp_cnt, 2);
        send(1'b1, 1'b1, 16'h0106, 16'h0109, 32'h11112222, 32'h33334444);
        repeat (3) @(posedge clk);
        #1;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk("t2_hold_req",  32'(wr_if.scrub_wr_req), 32'h1);
            chk("t2_hold_addr", 32'(wr_if.scrub_wr_addr), 32'h0106);
            chk("t2_hold_data", wr_if.scrub_wr_data, 32'h11112222);
            step();
        end
        wr_if.scrub_wr_gnt = 1'b1;
        repeat (6) step();
        chk("t2_drained", 32'(exp_q.size()), 32'h0);
        chk("t2_cnt", 32'(scrub_err_cnt), exp_count());

        // flush: A killed in DC4, B killed in DC5, C (hi-only) written
        send(1'b1, 1'b0, 16'h0300, 16'h0000, 32'hAAAA0000, 32'h0);
        flush_dc4 = 1'b1;
        step();
        flush_dc4 = 1'b0;
        send(1'b1, 1'b1, 16'h0304, 16'h0306, 32'hBBBB0000, 32'hBBBB0001);
        step();
        flush_dc5 = 1'b1;
        step();
        flush_dc5 = 1'b0;
        exp_q.push_back({16'h0308, 32'hCCCC0001});
        exp_cnt = sat_add(exp_cnt, 1);
        send(1'b0, 1'b1, 16'h0000, 16'h0308, 32'h0, 32'hCCCC0001);
        repeat (8) step();
        chk("t3_drained", 32'(exp_q.size()), 32'h0);
        chk("t3_cnt", 32'(scrub_err_cnt), exp_count());
        chk("t3_no_drop", 32'(drop_seen - drop_base), 32'h0);

        // overflow: three commits with gnt low, third dropped
        wr_if.scrub_wr_gnt = 1'b0;
        drop_base = drop_seen;
        for (int i = 0; i < 3; i++) begin
            set_ev(1'b1, 1'b0, 16'(16'h0200 + 4 * i), 16'h0, 32'hA0000000 + i, 32'h0);
            if (i < 2) exp_q.push_back({16'(16'h0200 + 4 * i), 32'hA0000000 + i});
            exp_cnt = sat_add(exp_cnt, 1);
            step();
        end
        set_ev(1'b0, 1'b0, 16'h0, 16'h0, 32'h0, 32'h0);
        repeat (5) step();
        @(negedge clk);
        chk("t4_full", 32'(scrub_full), 32'h1);
        chk("t4_drop", 32'(drop_seen - drop_base), 32'h1);
        chk("t4_cnt", 32'(scrub_err_cnt), exp_count());
        step();
        wr_if.scrub_wr_gnt = 1'b1;
        repeat (10) step();
        wr_if.scrub_wr_gnt = 1'b0;
        chk("t4_drained", 32'(exp_q.size()), 32'h0);
        chk("t4_not_full", 32'(scrub_full), 32'h0);

        // full FIFO, pop in the same cycle as a commit
        drop_base = drop_seen;
        for (int i = 0; i < 2; i++) begin
            set_ev(1'b1, 1'b0, 16'(16'h0500 + 4 * i), 16'h0, 32'hE0000000 + i, 32'h0);
            exp_q.push_back({16'(16'h0500 + 4 * i), 32'hE0000000 + i});
            exp_cnt = sat_add(exp_cnt, 1);
            step();
        end
        set_ev(1'b0, 1'b0, 16'h0, 16'h0, 32'h0, 32'h0);
        repeat (4) step();
        @(negedge clk);
        chk("t5_full_before", 32'(scrub_full), 32'h1);
        step();
        exp_q.push_back({16'h0508, 32'hE0000002});
        exp_cnt = sat_add(exp_cnt, 1);
        send(1'b1, 1'b0, 16'h0508, 16'h0, 32'hE0000002, 32'h0);
        step();
        wr_if.scrub_wr_gnt = 1'b1;
        step();
        wr_if.scrub_wr_gnt = 1'b0;
        @(negedge clk);
        chk("t5_full_after", 32'(scrub_full), 32'h1);
        step();
        chk("t5_no_drop", 32'(drop_seen - drop_base), 32'h0);
        wr_if.scrub_wr_gnt = 1'b1;
        repeat (10) step();
        wr_if.scrub_wr_gnt = 1'b0;
        chk("t5_drained", 32'(exp_q.size()), 32'h0);
        chk("t5_cnt", 32'(scrub_err_cnt), exp_count());

        // counter saturation, then reset during WR_HI
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_cnt = 0;
        step();
        drop_base = drop_seen;
        set_ev(1'b1, 1'b1, 16'h0400, 16'h0404, 32'h5A5A5A5A, 32'hA5A5A5A5);
        for (int i = 0; i < 32767; i++) begin
            step();
            exp_cnt = sat_add(exp_cnt, 2);
        end
        set_ev(1'b0, 1'b0, 16'h0, 16'h0, 32'h0, 32'h0);
        repeat (4) step();
        chk("t6_cnt_fffe", 32'(scrub_err_cnt), exp_count());
        for (int i = 0; i < 2; i++) begin
            send(1'b1, 1'b1, 16'h0410, 16'h0414, 32'h0, 32'h0);
            exp_cnt = sat_add(exp_cnt, 2);
            repeat (4) step();
            chk("t6_cnt_sat", 32'(scrub_err_cnt), exp_count());
        end
        chk("t6_drops", 32'(drop_seen - drop_base), 32'd32767);
        exp_q.push_back({16'h0400, 32'h5A5A5A5A});
        wr_if.scrub_wr_gnt = 1'b1;
        step();
        wr_if.scrub_wr_gnt = 1'b0;
        @(negedge clk);
        chk("t6_wr_hi_req",  32'(wr_if.scrub_wr_req), 32'h1);
        chk("t6_wr_hi_addr", 32'(wr_if.scrub_wr_addr), 32'h0404);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("t6_rst_req",  32'(wr_if.scrub_wr_req), 32'h0);
        chk("t6_rst_full", 32'(scrub_full), 32'h0);
        chk("t6_rst_cnt",  32'(scrub_err_cnt), 32'h0);
        step();
        wr_if.scrub_wr_gnt = 1'b1;
        repeat (5) step();
        @(negedge clk);
        chk("t6_empty_req", 32'(wr_if.scrub_wr_req), 32'h0);
        chk("t6_drained", 32'(exp_q.size()), 32'h0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
